// File: rtl/audio_sequencer.sv
// audio_sequencer: note-table player emitting a frequency word and gate on a 48 kHz tick grid
module audio_sequencer #(
    parameter int DEPTH     = 16,
    parameter int TICK_DIV  = 259,
    parameter int GAP_TICKS = 48
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_we_i,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr_i,
    input  logic [15:0]              cfg_freq_i,
    input  logic [15:0]              cfg_dur_i,
    input  logic [$clog2(DEPTH):0]   len_i,
    input  logic                     loop_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    output logic [15:0]              freq_o,
    output logic                     gate_o,
    output logic [$clog2(DEPTH)-1:0] note_idx_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     tick_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TICK_DIV + 1);
    localparam int GW = $clog2(GAP_TICKS + 2);
    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;
    state_t        state_q;
    logic [CW-1:0] tick_q;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q;
    logic          loop_q, gate_q, last, adv, fetch;
    logic [15:0]   freq_q, dur_q, ent_freq, ent_dur;
    logic [GW-1:0] gap_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tick_q <= '0;
        else tick_q <= tick_o ? '0 : tick_q + 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (cfg_we_i) mem_q[cfg_addr_i] <= {cfg_freq_i, cfg_dur_i};
    end
    always_comb begin
        tick_o   = tick_q == CW'(TICK_DIV);
        last     = {1'b0, idx_q} == len_q - 1'b1;
        idx_d    = (state_q == IDLE || last) ? '0 : idx_q + 1'b1;
        ent_freq = mem_q[idx_d][31:16];
        ent_dur  = mem_q[idx_d][15:0];
        adv      = tick_o && ((state_q == PLAY && dur_q == 16'd1 && GAP_TICKS == 0) ||
                              (state_q == GAP && gap_q == GW'(1)));
        fetch    = (state_q == IDLE && start_i && len_i != '0) || (adv && !(last && !loop_q));
    end
    // fetch covers both the start of a sequence and every advance that stays in the sequence
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            freq_q  <= '0;
            dur_q   <= '0;
            gate_q  <= 1'b0;
            gap_q   <= '0;
        end else if (stop_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            freq_q  <= '0;
            gate_q  <= 1'b0;
        end else if (fetch) begin
            if (state_q == IDLE) begin
                len_q  <= (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
                loop_q <= loop_i;
            end
            state_q <= PLAY;
            idx_q   <= idx_d;
            freq_q  <= ent_freq;
            gate_q  <= |ent_freq;
            dur_q   <= (ent_dur == '0) ? 16'd1 : ent_dur;
        end else if (adv) begin
            state_q <= DONE;
            freq_q  <= '0;
            gate_q  <= 1'b0;
        end else if (state_q == DONE) begin
            state_q <= IDLE;
        end else if (tick_o && state_q == PLAY) begin
            if (dur_q != 16'd1) dur_q <= dur_q - 1'b1;
            else begin
                state_q <= GAP;
                gate_q  <= 1'b0;
                gap_q   <= GW'(GAP_TICKS);
            end
        end else if (tick_o && state_q == GAP) begin
            gap_q <= gap_q - 1'b1;
        end
    end
    assign freq_o     = freq_q;
    assign gate_o     = gate_q;
    assign note_idx_o = idx_q;
    assign busy_o     = state_q == PLAY || state_q == GAP;
    assign done_o     = state_q == DONE;
endmodule

// File: doc/audio_sequencer.md
AUDIO_SEQUENCER -- requirements
Module: audio_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of note-table entries.
REQ-002 SHALL have parameter TICK_DIV, default 259, meaning the 48 kHz tick divider terminal count (tick period TICK_DIV+1 clocks).
REQ-003 SHALL have parameter GAP_TICKS, default 48, meaning silent ticks between consecutive notes (0 = no gap).
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-005 SHALL have port rst_i, input, 1, meaning the asynchronous, active-high reset.
REQ-006 SHALL have ports cfg_we_i in 1, cfg_addr_i in $clog2(DEPTH), cfg_freq_i in 16, cfg_dur_i in 16, meaning the note-table write strobe, index, phase-increment word and duration in ticks.
REQ-007 SHALL have ports len_i in $clog2(DEPTH)+1, loop_i in 1, start_i in 1, stop_i in 1, meaning sequence length, repeat enable, start pulse and abort pulse.
REQ-008 SHALL have ports freq_o out 16, gate_o out 1, note_idx_o out $clog2(DEPTH), meaning oscillator frequency word, note-on, and current entry.
REQ-009 SHALL have ports busy_o out 1, done_o out 1, tick_o out 1, meaning sequence active, one-cycle completion pulse, and the 48 kHz tick.

Function
REQ-010 Tick counter SHALL count 0..TICK_DIV and wrap; tick_o SHALL be high for exactly the cycle where count == TICK_DIV; it SHALL free-run in all states.
REQ-011 A cfg_we_i cycle SHALL write {cfg_freq_i, cfg_dur_i} into entry cfg_addr_i on the next clock edge, in any state.
REQ-012 FSM states SHALL be IDLE, PLAY, GAP, DONE.
REQ-013 IDLE: start_i with len_i != 0 SHALL latch len (clamped to DEPTH) and loop_i, set idx=0 and enter PLAY next cycle; start_i with len_i == 0 SHALL be ignored.
REQ-014 PLAY entry SHALL load freq_o = entry[idx].freq, duration counter = max(entry[idx].dur, 1), and gate_o = (freq != 0); freq word 0 is a rest (gate_o stays 0).
REQ-015 In PLAY the duration counter SHALL decrement on each tick_o; the tick that takes it from 1 to 0 SHALL move the FSM to GAP next cycle (or directly to the advance step when GAP_TICKS == 0).
REQ-016 GAP SHALL drive gate_o = 0, hold freq_o, and count GAP_TICKS ticks before advancing.
REQ-017 Advance: if idx < len-1, idx increments and PLAY is re-entered; if idx == len-1 and loop latched, idx wraps to 0 and PLAY is re-entered; otherwise the FSM enters DONE.
REQ-018 DONE SHALL last one cycle with done_o = 1, freq_o = 0 and gate_o = 0, then return to IDLE.
REQ-019 busy_o SHALL be 1 in PLAY and GAP, 0 in IDLE and DONE.
REQ-020 freq_o SHALL be latched at PLAY entry only; a cfg write to the playing entry SHALL take effect at its next fetch.
REQ-021 start_i while busy_o = 1 SHALL be ignored; len_i and loop_i SHALL be sampled only at accepted start.
REQ-022 stop_i in any state SHALL force IDLE next cycle with freq_o = 0, gate_o = 0, idx = 0, and no done_o pulse; stop_i together with start_i SHALL resolve as stop.
REQ-023 note_idx_o SHALL equal idx at all times.

Reset
REQ-024 While rst_i = 1: FSM = IDLE, tick counter = 0, freq_o = 0, gate_o = 0, note_idx_o = 0, busy_o = 0, done_o = 0, tick_o = 0.
REQ-025 Reset asserted mid-sequence SHALL abort immediately; the note table contents SHALL NOT be cleared by reset.

Verification
REQ-026 Tick: release reset, count clocks -> tick_o pulses once every 260 cycles, first pulse 259 cycles after release.
REQ-027 Single note: entry0 = {4723, 4}, len 1, loop 0, start -> freq_o = 4723 with gate_o = 1 for 4 tick boundaries, gate_o = 0 for 48 ticks, one done_o pulse, freq_o = 0.
REQ-028 Loop/wrap: 3 entries {4723,2},{0,2},{9446,2}, loop 1 -> note_idx_o 0,1,2,0,...; gate_o = 0 throughout entry 1; done_o never asserts.
REQ-029 Abort: stop_i during the second note of a looping sequence -> next cycle IDLE, freq_o = 0, busy_o = 0, no done_o; stop_i + start_i together -> stays IDLE.
REQ-030 Edge cases: len_i = 0 start -> ignored; len_i = 20 -> clamped to 16 entries; dur = 0 -> plays 1 tick; GAP_TICKS = 0 -> gate_o stays 1 across back-to-back notes.
REQ-031 Live edit: write entry0.freq = 9446 while entry0 is playing -> freq_o unchanged until the next fetch of entry0, then 9446.
